// File: rtl/split_carry_resolve.sv
// Carry-resolve stage of the split adder: ripples per-chunk carries
// round by round until the chunked partial sum is exact.
module split_carry_resolve #(
  parameter int IO = 512,
  parameter int SS = (($clog2(IO) >> 2) > 0)
                   ? (1 << ($clog2(IO) >> 2))
                   : (1 << ($clog2(IO) >> 1)),
  localparam int NP = IO / SS + (((IO % SS) != 0) ? 1 : 0),
  localparam int RW = $clog2(NP) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IO-1:0] sum_in,
  input  logic [NP-1:0] cout_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IO-1:0] sum_out,
  output logic          cout_out,
  output logic [RW-1:0] rounds
);

  localparam int LW = IO - (NP - 1) * SS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RES,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [IO-1:0] r_sum;
  logic [NP-1:0] r_car;
  logic          r_ovf;
  logic [RW-1:0] r_cnt;

  logic [IO-1:0] w_sum_nxt;
  logic [NP-1:0] w_car_nxt;
  logic          w_more;
  logic          w_acc;

  // One ripple round: each chunk absorbs the carry of its lower neighbour
  for (genvar j = 0; j < NP; j++) begin : g_ch
    localparam int W = (j == NP - 1) ? LW : SS;
    logic       w_cin;
    logic [W:0] w_t;
    if (j == 0) begin : g_c0
      assign w_cin = 1'b0;
    end else begin : g_cn
      assign w_cin = r_car[j-1];
    end
    assign w_t = {1'b0, r_sum[j*SS +: W]}
               + {{W{1'b0}}, w_cin};
    assign w_sum_nxt[j*SS +: W] = w_t[W-1:0];
    assign w_car_nxt[j] = w_t[W];
  end

  // The top chunk's carry leaves the word, so it never forces a round
  assign w_more = |r_car[NP-2:0];
  assign w_acc  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt    = r_state;
    in_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nxt = S_RES;
      end
      S_RES: begin
        if (!w_more) w_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          w_nxt    = in_valid ? S_RES : S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_car <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_sum <= sum_in;
      r_car <= cout_in;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == S_RES) begin
      r_sum <= w_sum_nxt;
      r_car <= w_car_nxt;
      r_ovf <= r_ovf | r_car[NP-1];
      if (w_more) r_cnt <= r_cnt + RW'(1);
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign sum_out   = r_sum;
  assign cout_out  = r_ovf;
  assign rounds    = r_cnt;

endmodule

// File: tb/tb_split_carry_resolve.sv
// Bench for split_carry_resolve: directed handshake/reset cases plus
// random a+b traffic through a chunked round model (IO=16 and IO=18).
module tb_split_carry_resolve;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv;
  logic        ordy;
  logic        sel;
  logic [17:0] sin;
  logic [4:0]  cin;

  logic        ir16, ov16, co16;
  logic [15:0] so16;
  logic [2:0]  rd16;
  logic        ir18, ov18, co18;
  logic [17:0] so18;
  logic [3:0]  rd18;
  logic        iv16, iv18;

  assign iv16 = iv && !sel;
  assign iv18 = iv && sel;

  split_carry_resolve #(.IO(16), .SS(4)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16),
    .sum_in(sin[15:0]), .cout_in(cin[3:0]),
    .out_valid(ov16), .out_ready(ordy),
    .sum_out(so16), .cout_out(co16), .rounds(rd16)
  );

  split_carry_resolve #(.IO(18), .SS(4)) u18 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv18), .in_ready(ir18),
    .sum_in(sin), .cout_in(cin),
    .out_valid(ov18), .out_ready(ordy),
    .sum_out(so18), .cout_out(co18), .rounds(rd18)
  );

  logic        ir, ov, co;
  logic [17:0] so;
  logic [3:0]  rd;
  assign ir = sel ? ir18 : ir16;
  assign ov = sel ? ov18 : ov16;
  assign co = sel ? co18 : co16;
  assign so = sel ? so18 : {2'b00, so16};
  assign rd = sel ? rd18 : {1'b0, rd16};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Present one operand set, wait for accept, then count edges to out_valid
  task automatic run(input logic s, input logic [17:0] si,
                     input logic [4:0] ci, output int lat);
    int n;
    sel = s;
    sin = si;
    cin = ci;
    iv  = 1'b1;
    n   = 0;
    #1;
    while (!ir && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir) chk("accept_timeout", 32'(ir), 32'd1);
    @(posedge clk); #1;
    iv  = 1'b0;
    lat = 0;
    while (!ov && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov) chk("result_timeout", 32'(ov), 32'd1);
  endtask

  task automatic release_out();
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  // Round stage model: independent chunk adds; R is the longest chain of
  // all-ones chunks a carry must walk before landing (top chunk excluded).
  task automatic rmodel(input int io, input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [17:0] si, output logic [4:0] ci,
                        output int r);
    int np, w, m, k;
    logic [31:0] ca, cb, s, msk;
    np = (io + 3) / 4;
    si = '0;
    ci = '0;
    for (int j = 0; j < np; j++) begin
      w   = (j == np - 1) ? io - (np - 1) * 4 : 4;
      msk = (32'd1 << w) - 32'd1;
      ca  = (a >> (j * 4)) & msk;
      cb  = (b >> (j * 4)) & msk;
      s   = ca + cb;
      si  = si | 18'((s & msk) << (j * 4));
      ci[j] = s[w];
    end
    r = 0;
    for (int j = 0; j < np - 1; j++) begin
      if (ci[j]) begin
        m = 1;
        k = j + 1;
        while (k < np - 1 && ((si >> (k * 4)) & 18'hF) == 18'hF) begin
          m++;
          k++;
        end
        if (m > r) r = m;
      end
    end
  endtask

  initial begin
    int lat, r, io, np;
    logic [31:0] a, b, msk;
    logic [32:0] tot;
    logic [17:0] si;
    logic [4:0]  ci;

    rst_n = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b0;
    sel   = 1'b0;
    sin   = '0;
    cin   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_sum", 32'(so), 32'd0);
    chk("rst_cout", 32'(co), 32'd0);
    chk("rst_rounds", 32'(rd), 32'd0);
    chk("rst_in_ready", 32'(ir), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(1'b0, 18'h1234, 5'b0000, lat);
    chk("c1_lat", 32'(lat), 32'd1);
    chk("c1_sum", 32'(so), 32'h1234);
    chk("c1_cout", 32'(co), 32'd0);
    chk("c1_rounds", 32'(rd), 32'd0);
    release_out();

    run(1'b0, 18'hFFF0, 5'b0001, lat);
    chk("c2_lat", 32'(lat), 32'd4);
    chk("c2_sum", 32'(so), 32'h0000);
    chk("c2_cout", 32'(co), 32'd1);
    chk("c2_rounds", 32'(rd), 32'd3);
    release_out();

    run(1'b0, 18'hF0F0, 5'b0101, lat);
    chk("c3_lat", 32'(lat), 32'd3);
    chk("c3_sum", 32'(so), 32'h0100);
    chk("c3_cout", 32'(co), 32'd1);
    chk("c3_rounds", 32'(rd), 32'd2);
    release_out();

    run(1'b0, 18'h00F0, 5'b0001, lat);
    chk("c4_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("c4_hold_valid", 32'(ov), 32'd1);
      chk("c4_hold_sum", 32'(so), 32'h0100);
      chk("c4_hold_rounds", 32'(rd), 32'd2);
      chk("c4_hold_ready", 32'(ir), 32'd0);
    end
    sin  = 18'h0ABC;
    cin  = 5'b0000;
    iv   = 1'b1;
    ordy = 1'b1;
    #1;
    chk("c4_ready_handoff", 32'(ir), 32'd1);
    @(posedge clk); #1;
    iv   = 1'b0;
    ordy = 1'b0;
    chk("c4_valid_drop", 32'(ov), 32'd0);
    @(posedge clk); #1;
    chk("c4_next_valid", 32'(ov), 32'd1);
    chk("c4_next_sum", 32'(so), 32'h0ABC);
    chk("c4_next_cout", 32'(co), 32'd0);
    release_out();

    sin = 18'hFFF0;
    cin = 5'b0001;
    iv  = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("c5_valid", 32'(ov), 32'd0);
    chk("c5_sum", 32'(so), 32'd0);
    chk("c5_ready", 32'(ir), 32'd1);
    chk("c5_cout", 32'(co), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(1'b0, 18'hF0F0, 5'b0101, lat);
    chk("c5_after_lat", 32'(lat), 32'd3);
    chk("c5_after_sum", 32'(so), 32'h0100);
    chk("c5_after_cout", 32'(co), 32'd1);
    release_out();

    for (int i = 0; i < 8000; i++) begin
      sel = (i >= 4000);
      io  = sel ? 18 : 16;
      np  = (io + 3) / 4;
      msk = (32'd1 << io) - 32'd1;
      a   = $urandom & msk;
      b   = $urandom & msk;
      if ($urandom_range(0, 2) == 0)
        b = ((msk - a) + 32'($urandom_range(0, 2))) & msk;
      rmodel(io, a, b, si, ci, r);
      run(sel, si, ci, lat);
      tot = {1'b0, a} + {1'b0, b};
      chk("rnd_sum", 32'(so), tot[31:0] & msk);
      chk("rnd_cout", 32'(co), 32'(tot[io]));
      chk("rnd_rounds", 32'(rd), 32'(r));
      chk("rnd_lat", 32'(lat), 32'(r + 1));
      chk("rnd_bound", 32'(32'(rd) <= 32'(np - 1)), 32'd1);
      release_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
